// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: arbitrates one READ/WRITE/NOP per cycle on the shared reg1 port, buffers writebacks.
// Latency: operand response 1 cycle after READ issue; a queued writeback reaches the register file no earlier than 1 cycle after acceptance.
// Backpressure: rd_ready drops on full queue, busy response slot, hazard or drain; wb_ready drops on full queue or drain. Optional RF_FWD_EN forwards queued data.
module regfile_access_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int WQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_src1,
    input  logic [ADDR_W-1:0] rd_src2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              drain_req,
    output logic              drain_done,
    output logic              rf_read_enable,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_reg1,
    output logic [ADDR_W-1:0] rf_reg2,
    output logic [DATA_W-1:0] rf_in_data,
    input  logic [DATA_W-1:0] rf_out_data1,
    input  logic [DATA_W-1:0] rf_out_data2,
    output logic [2:0]        wq_count
);
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DRAINED} state_t;
    localparam logic [2:0] DEPTH_C = 3'(WQ_DEPTH);

    state_t            state_q, state_d;
    logic              drain_done_q, drain_done_d;
    logic [2:0]        count_q, count_d;
    logic [ADDR_W-1:0] dest_q [WQ_DEPTH];
    logic [ADDR_W-1:0] dest_d [WQ_DEPTH];
    logic [DATA_W-1:0] wdat_q [WQ_DEPTH];
    logic [DATA_W-1:0] wdat_d [WQ_DEPTH];
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data1_q, rsp_data1_d;
    logic [DATA_W-1:0] rsp_data2_q, rsp_data2_d;

    logic              full, empty, slot_free, blocked;
    logic              issue_rd, issue_wr, push, pop;
    logic [DATA_W-1:0] rd_data1, rd_data2;
    logic [2:0]        slot;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == 3'd0);
    assign slot_free = !rsp_valid_q || rsp_ready;

`ifdef RF_FWD_EN
    // Operand select: youngest queued entry for a source overrides the register file
    always_comb begin
        blocked  = 1'b0;
        rd_data1 = rf_out_data1;
        rd_data2 = rf_out_data2;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            if (3'(i) < count_q && dest_q[i] == rd_src1) rd_data1 = wdat_q[i];
            if (3'(i) < count_q && dest_q[i] == rd_src2) rd_data2 = wdat_q[i];
        end
    end
`else
    // Hazard check: any queued destination matching a source stalls the read
    always_comb begin
        blocked  = 1'b0;
        rd_data1 = rf_out_data1;
        rd_data2 = rf_out_data2;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            if (3'(i) < count_q && (dest_q[i] == rd_src1 || dest_q[i] == rd_src2)) blocked = 1'b1;
        end
    end
`endif

    // Port arbitration: full queue beats reads, reads beat opportunistic writes
    always_comb begin
        issue_rd = 1'b0;
        issue_wr = 1'b0;
        if (!rst) begin
            if (full)
                issue_wr = 1'b1;
            else if (rd_valid && slot_free && !blocked && state_q == ST_RUN)
                issue_rd = 1'b1;
            else if (!empty)
                issue_wr = 1'b1;
        end
    end

    assign rd_ready        = issue_rd;
    assign wb_ready        = !rst && !full && (state_q == ST_RUN);
    assign rf_read_enable  = issue_rd;
    assign rf_write_enable = issue_wr;
    assign rf_reg1         = issue_rd ? rd_src1 : (issue_wr ? dest_q[0] : '0);
    assign rf_reg2         = issue_rd ? rd_src2 : '0;
    assign rf_in_data      = issue_wr ? wdat_q[0] : '0;
    assign push            = wb_valid && wb_ready;
    assign pop             = issue_wr;

    // Writeback queue: shift toward head on pop, append at the tail on push
    always_comb begin
        dest_d  = dest_q;
        wdat_d  = wdat_q;
        slot    = pop ? (count_q - 3'd1) : count_q;
        count_d = count_q + 3'(push) - 3'(pop);
        if (pop) begin
            for (int i = 0; i < WQ_DEPTH - 1; i++) begin
                dest_d[i] = dest_q[i+1];
                wdat_d[i] = wdat_q[i+1];
            end
        end
        for (int i = 0; i < WQ_DEPTH; i++) begin
            if (push && 3'(i) == slot) begin
                dest_d[i] = wb_dest;
                wdat_d[i] = wb_data;
            end
        end
    end

    // Response slot: load on READ, clear on consume, otherwise hold
    always_comb begin
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_data1_d = rsp_data1_q;
        rsp_data2_d = rsp_data2_q;
        if (issue_rd) begin
            rsp_valid_d = 1'b1;
            rsp_data1_d = rd_data1;
            rsp_data2_d = rd_data2;
        end
    end

    // Drain sequencing: quiesce once queue and response slot will both be empty
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN:   if (count_d == 3'd0 && !rsp_valid_d) state_d = ST_DRAINED;
            ST_DRAINED: if (!drain_req) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
        drain_done_d = (state_d == ST_DRAINED);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            drain_done_q <= 1'b0;
            count_q      <= 3'd0;
            rsp_valid_q  <= 1'b0;
            rsp_data1_q  <= '0;
            rsp_data2_q  <= '0;
            for (int i = 0; i < WQ_DEPTH; i++) begin
                dest_q[i] <= '0;
                wdat_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            drain_done_q <= drain_done_d;
            count_q      <= count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data1_q  <= rsp_data1_d;
            rsp_data2_q  <= rsp_data2_d;
            dest_q       <= dest_d;
            wdat_q       <= wdat_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data1  = rsp_data1_q;
    assign rsp_data2  = rsp_data2_q;
    assign drain_done = drain_done_q;
    assign wq_count   = count_q;
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: register-file model, queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations. Optional RF_FWD_EN changes the expected hazard stall.
module tb_regfile_access_ctrl;
    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int WQD = 2;
`ifdef RF_FWD_EN
    localparam int EXP_STALLS = 0;
`else
    localparam int EXP_STALLS = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_valid, rd_ready, rsp_valid, rsp_ready, wb_valid, wb_ready;
    logic [AW-1:0] rd_src1, rd_src2, wb_dest, rf_reg1, rf_reg2;
    logic [DW-1:0] rsp_data1, rsp_data2, wb_data, rf_in_data, rf_out_data1, rf_out_data2;
    logic          drain_req, drain_done, rf_read_enable, rf_write_enable;
    logic [2:0]    wq_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    regfile_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WQ_DEPTH(WQD)) dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_src1(rd_src1), .rd_src2(rd_src2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_data(wb_data),
        .drain_req(drain_req), .drain_done(drain_done),
        .rf_read_enable(rf_read_enable), .rf_write_enable(rf_write_enable),
        .rf_reg1(rf_reg1), .rf_reg2(rf_reg2), .rf_in_data(rf_in_data),
        .rf_out_data1(rf_out_data1), .rf_out_data2(rf_out_data2), .wq_count(wq_count)
    );

    always #5 clk = ~clk;

    // Register file: combinational read, write at the edge; contents reload to 0x1000+i on rst
    logic [DW-1:0] rf [16];
    assign rf_out_data1 = rf[rf_reg1];
    assign rf_out_data2 = rf[rf_reg2];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'h1000 + 16'(i);
        end else if (rf_write_enable) begin
            rf[rf_reg1] <= rf_in_data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct packed {
        logic [AW-1:0] d;
        logic [DW-1:0] v;
    } ent_t;
    ent_t          mq[$];
    logic [DW-1:0] m_rf [16];
    bit            m_rsp_valid = 1'b0;
    logic [DW-1:0] m_d1 = '0;
    logic [DW-1:0] m_d2 = '0;
    int            m_state = 0;   // 0 running, 1 draining, 2 drained
    bit            e_full, e_haz, e_blk, e_rd, e_wr, e_wbr;
    logic [AW-1:0] e_reg1, e_reg2;
    logic [DW-1:0] e_in;

    function automatic logic [DW-1:0] mval(input logic [AW-1:0] s);
        logic [DW-1:0] v;
        v = m_rf[s];
        for (int i = 0; i < mq.size(); i++) if (mq[i].d == s) v = mq[i].v;
        return v;
    endfunction

    // Every cycle: predict outputs from the model, compare, then advance the model
    always @(negedge clk) begin
        if (chk_en) begin
            e_full = (mq.size() == WQD);
            e_haz  = 1'b0;
            for (int i = 0; i < mq.size(); i++)
                if (mq[i].d == rd_src1 || mq[i].d == rd_src2) e_haz = 1'b1;
`ifdef RF_FWD_EN
            e_blk = 1'b0;
`else
            e_blk = e_haz;
`endif
            e_rd = 1'b0; e_wr = 1'b0; e_wbr = 1'b0;
            if (!rst) begin
                e_wbr = !e_full && (m_state == 0);
                if (e_full) e_wr = 1'b1;
                else if (rd_valid && (!m_rsp_valid || rsp_ready) && !e_blk && m_state == 0) e_rd = 1'b1;
                else if (mq.size() > 0) e_wr = 1'b1;
            end
            e_reg1 = '0; e_reg2 = '0; e_in = '0;
            if (e_rd) begin
                e_reg1 = rd_src1; e_reg2 = rd_src2;
            end else if (e_wr) begin
                e_reg1 = mq[0].d; e_in = mq[0].v;
            end
            chk("m_rd_ready",   32'(rd_ready),        32'(e_rd));
            chk("m_wb_ready",   32'(wb_ready),        32'(e_wbr));
            chk("m_rf_re",      32'(rf_read_enable),  32'(e_rd));
            chk("m_rf_we",      32'(rf_write_enable), 32'(e_wr));
            chk("m_rf_reg1",    32'(rf_reg1),         32'(e_reg1));
            chk("m_rf_reg2",    32'(rf_reg2),         32'(e_reg2));
            chk("m_rf_in_data", 32'(rf_in_data),      32'(e_in));
            chk("m_wq_count",   32'(wq_count),        32'(mq.size()));
            chk("m_rsp_valid",  32'(rsp_valid),       32'(m_rsp_valid));
            chk("m_rsp_data1",  32'(rsp_data1),       32'(m_d1));
            chk("m_rsp_data2",  32'(rsp_data2),       32'(m_d2));
            chk("m_drain_done", 32'(drain_done),      32'(m_state == 2));
            if (rst) begin
                mq.delete();
                m_rsp_valid = 1'b0; m_d1 = '0; m_d2 = '0; m_state = 0;
                for (int i = 0; i < 16; i++) m_rf[i] = 16'h1000 + 16'(i);
            end else begin
                if (e_rd) begin
                    m_d1 = mval(rd_src1); m_d2 = mval(rd_src2); m_rsp_valid = 1'b1;
                end else if (rsp_ready) begin
                    m_rsp_valid = 1'b0;
                end
                if (e_wr) begin
                    m_rf[mq[0].d] = mq[0].v;
                    void'(mq.pop_front());
                end
                if (wb_valid && e_wbr) mq.push_back(ent_t'{wb_dest, wb_data});
                case (m_state)
                    0: if (drain_req) m_state = 1;
                    1: if (mq.size() == 0 && !m_rsp_valid) m_state = 2;
                    default: if (!drain_req) m_state = 0;
                endcase
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int stalls;

    initial begin
        rst = 1'b1; rd_valid = 1'b1; rd_src1 = '0; rd_src2 = '0; rsp_ready = 1'b1;
        wb_valid = 1'b0; wb_dest = '0; wb_data = '0; drain_req = 1'b0;
        // Reset
        cyc(); chk_en = 1'b1; #1;
        chk("rst_rd_ready",   32'(rd_ready), 0);
        chk("rst_wb_ready",   32'(wb_ready), 0);
        chk("rst_rf_re",      32'(rf_read_enable), 0);
        chk("rst_wq_count",   32'(wq_count), 0);
        chk("rst_rsp_valid",  32'(rsp_valid), 0);
        chk("rst_drain_done", 32'(drain_done), 0);
        // First cycle out of reset
        cyc(); rst = 1'b0; rd_src1 = 4'd0; rd_src2 = 4'd1; #1;
        chk("rel_rd_ready", 32'(rd_ready), 1);
        chk("rel_wb_ready", 32'(wb_ready), 1);
        chk("rel_rf_reg2",  32'(rf_reg2), 1);
        cyc(); rd_valid = 1'b0; #1;
        chk("rel_rsp_valid", 32'(rsp_valid), 1);
        chk("rel_rsp_data1", 32'(rsp_data1), 32'h1000);
        chk("rel_rsp_data2", 32'(rsp_data2), 32'h1001);
        // Writeback then read
        cyc(); wb_valid = 1'b1; wb_dest = 4'd3; wb_data = 16'h1234; #1;
        chk("wb_ready_empty", 32'(wb_ready), 1);
        cyc(); wb_dest = 4'd5; wb_data = 16'hBEEF; #1;
        chk("wr1_we",   32'(rf_write_enable), 1);
        chk("wr1_reg1", 32'(rf_reg1), 3);
        chk("wr1_data", 32'(rf_in_data), 32'h1234);
        cyc(); wb_valid = 1'b0; #1;
        chk("wr2_reg1", 32'(rf_reg1), 5);
        chk("wr2_data", 32'(rf_in_data), 32'hBEEF);
        cyc(); rd_valid = 1'b1; rd_src1 = 4'd3; rd_src2 = 4'd5; #1;
        chk("rd35_count", 32'(wq_count), 0);
        chk("rd35_ready", 32'(rd_ready), 1);
        cyc(); rd_valid = 1'b0; #1;
        chk("rd35_data1", 32'(rsp_data1), 32'h1234);
        chk("rd35_data2", 32'(rsp_data2), 32'hBEEF);
        // Read-after-write hazard
        cyc(); wb_valid = 1'b1; wb_dest = 4'd7; wb_data = 16'hA5A5; #1;
        cyc(); wb_valid = 1'b0; rd_valid = 1'b1; rd_src1 = 4'd7; rd_src2 = 4'd2; #1;
        stalls = 0;
        while (rd_ready !== 1'b1 && stalls < 10) begin
            cyc(); #1; stalls++;
        end
        chk("haz_stalls", 32'(stalls), 32'(EXP_STALLS));
        cyc(); rd_valid = 1'b0; #1;
        chk("haz_data1", 32'(rsp_data1), 32'hA5A5);
        chk("haz_data2", 32'(rsp_data2), 32'h1002);
        cyc(); cyc();
        // Queue full forces WRITE over a pending read
        cyc(); rd_valid = 1'b1; rd_src1 = 4'd0; rd_src2 = 4'd1;
        wb_valid = 1'b1; wb_dest = 4'd9; wb_data = 16'h0909; #1;
        chk("qf_rd0", 32'(rd_ready), 1);
        cyc(); wb_dest = 4'd10; wb_data = 16'h0A0A; #1;
        chk("qf_rd1",    32'(rd_ready), 1);
        chk("qf_wbr1",   32'(wb_ready), 1);
        cyc(); wb_valid = 1'b0; #1;
        chk("qf_count",  32'(wq_count), 2);
        chk("qf_wbr",    32'(wb_ready), 0);
        chk("qf_rd",     32'(rd_ready), 0);
        chk("qf_reg1",   32'(rf_reg1), 9);
        cyc(); #1;
        chk("qf_after_pop_rd", 32'(rd_ready), 1);
        cyc(); rd_valid = 1'b0; #1;
        chk("qf_last_reg1", 32'(rf_reg1), 10);
        cyc(); cyc();
        // Response backpressure
        cyc(); rd_valid = 1'b1; rd_src1 = 4'd4; rd_src2 = 4'd6; rsp_ready = 1'b0; #1;
        chk("bp_rd0", 32'(rd_ready), 1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (k == 0) begin rd_src1 = 4'd8; rd_src2 = 4'd9; end
            #1;
            chk("bp_rd_hold",   32'(rd_ready), 0);
            chk("bp_data1_hold", 32'(rsp_data1), 32'h1004);
            chk("bp_data2_hold", 32'(rsp_data2), 32'h1006);
        end
        cyc(); rsp_ready = 1'b1; #1;
        chk("bp_release_rd", 32'(rd_ready), 1);
        cyc(); rd_valid = 1'b0; #1;
        chk("bp_next_data1", 32'(rsp_data1), 32'h1008);
        chk("bp_next_data2", 32'(rsp_data2), 32'h0909);
        cyc();
        // Drain with two entries queued
        cyc(); rd_valid = 1'b1; rd_src1 = 4'd0; rd_src2 = 4'd1;
        wb_valid = 1'b1; wb_dest = 4'd12; wb_data = 16'hC0C0; #1;
        cyc(); wb_dest = 4'd13; wb_data = 16'hD0D0; #1;
        cyc(); wb_dest = 4'd14; wb_data = 16'hE0E0; drain_req = 1'b1; #1;
        chk("dr_w1_rd",   32'(rd_ready), 0);
        chk("dr_w1_wb",   32'(wb_ready), 0);
        chk("dr_w1_reg1", 32'(rf_reg1), 12);
        cyc(); #1;
        chk("dr_w2_rd",   32'(rd_ready), 0);
        chk("dr_w2_wb",   32'(wb_ready), 0);
        chk("dr_w2_reg1", 32'(rf_reg1), 13);
        chk("dr_w2_done", 32'(drain_done), 0);
        cyc(); #1;
        chk("dr_done",    32'(drain_done), 1);
        chk("dr_idle_we", 32'(rf_write_enable), 0);
        chk("dr_idle_wb", 32'(wb_ready), 0);
        cyc(); drain_req = 1'b0; #1;
        chk("dr_still_done", 32'(drain_done), 1);
        cyc(); #1;
        chk("run_done",  32'(drain_done), 0);
        chk("run_rd",    32'(rd_ready), 1);
        chk("run_wb",    32'(wb_ready), 1);
        cyc(); rd_valid = 1'b0; wb_valid = 1'b0; #1;
        cyc(); cyc();
        // Reset mid-operation discards queue and pending response
        cyc(); rd_valid = 1'b1; rd_src1 = 4'd0; rd_src2 = 4'd1; rsp_ready = 1'b0;
        wb_valid = 1'b1; wb_dest = 4'd15; wb_data = 16'hF0F0; #1;
        cyc(); rd_valid = 1'b0; wb_valid = 1'b0; rst = 1'b1; #1;
        chk("mr_rsp_pending", 32'(rsp_valid), 1);
        chk("mr_count",       32'(wq_count), 1);
        chk("mr_we",          32'(rf_write_enable), 0);
        cyc(); rst = 1'b0; rsp_ready = 1'b1; rd_valid = 1'b1; rd_src1 = 4'd15; rd_src2 = 4'd14; #1;
        chk("mr_count_clr", 32'(wq_count), 0);
        chk("mr_rsp_clr",   32'(rsp_valid), 0);
        chk("mr_rd",        32'(rd_ready), 1);
        cyc(); rd_valid = 1'b0; #1;
        chk("mr_data1", 32'(rsp_data1), 32'h100F);
        chk("mr_data2", 32'(rsp_data2), 32'h100E);
        cyc(); cyc(); cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Access controller sitting on the requester side of the 16x16 register file. It takes operand-read requests from decode and writeback requests from the execute/writeback stage. It drives the register file's shared-address port (reg1 serves as both write address and read address 1) and buffers writebacks in a small queue. It resolves read-after-write hazards against that queue and returns operand pairs to decode through a valid/ready response channel.

## Interface
Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register index width (16 registers)
- WQ_DEPTH, 2, writeback queue entries, legal range 1..4

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- rd_valid  in  1  operand-read request valid
- rd_ready  out  1  read request accepted this cycle when rd_valid && rd_ready
- rd_src1, rd_src2  in  ADDR_W  source register indices
- rsp_valid  out  1  operand response valid
- rsp_ready  in  1  consumer accepts response
- rsp_data1, rsp_data2  out  DATA_W  operand values for src1/src2
- wb_valid  in  1  writeback request valid
- wb_ready  out  1  writeback accepted when wb_valid && wb_ready
- wb_dest  in  ADDR_W  destination register
- wb_data  in  DATA_W  writeback value
- drain_req  in  1  request to empty the write queue and quiesce
- drain_done  out  1  quiesced (state DRAINED)
- rf_read_enable  out  1  to register file read_enable
- rf_write_enable  out  1  to register file write_enable
- rf_reg1  out  ADDR_W  to register file reg1 (write address / read address 1)
- rf_reg2  out  ADDR_W  to register file reg2
- rf_in_data  out  DATA_W  to register file in_data
- rf_out_data1, rf_out_data2  in  DATA_W  register file read data, combinational from reg1/reg2
- wq_count  out  3  current queue occupancy

## Operation
- Write queue: FIFO of {dest, data}. Push on wb handshake. Pop when a WRITE is issued. Simultaneous push and pop is allowed; count is unchanged. wb_ready = !full && state==RUN.
- Each cycle issues exactly one of READ, WRITE, or NOP, because reg1 is shared. Priority order:
  1. queue full -> WRITE
  2. rd_valid && response slot free && no blocking hazard && state==RUN -> READ
  3. queue non-empty -> WRITE
  4. NOP
- Response slot free = !rsp_valid || rsp_ready. rd_ready is high exactly when READ is issued.
- READ drives: rf_read_enable=1, rf_reg1=rd_src1, rf_reg2=rd_src2, rf_write_enable=0, rf_in_data=0.
- WRITE drives: rf_write_enable=1, rf_reg1=head dest, rf_in_data=head data, rf_read_enable=0, rf_reg2=0.
- NOP drives all rf_* outputs to 0.
- Hazard: a source index matches the dest of any queued entry. Entries pushed in the same cycle are not yet queued; upstream must not present a read that depends on a same-cycle writeback.
- States and transitions:
  - RUN -> DRAIN when drain_req=1.
  - DRAIN: rd_ready=0, wb_ready=0, WRITE issued every cycle while the queue is non-empty. DRAIN -> DRAINED when the queue is empty and rsp_valid=0.
  - DRAINED: drain_done=1. DRAINED -> RUN when drain_req=0.
  - drain_req deasserted while in DRAIN has no effect; the drain always completes.
- Reset: state=RUN, queue empty, wq_count=0, rsp_valid=0, rsp_data1/2=0, drain_done=0. While rst=1, rd_ready, wb_ready and all rf_* outputs are 0.

## Timing
- READ issued in cycle N: rf_out_data is sampled at the end of N. rsp_valid=1 and rsp_data are valid from N+1. Latency is 1 cycle.
- rsp_data is held stable while rsp_valid && !rsp_ready. A READ issued in the same cycle that the response is consumed replaces the response back-to-back.
- WRITE issued in cycle N: the register file captures the value at the end of N. A READ in N+1 observes it.
- Writeback accepted in N: earliest WRITE issue is N+1.
- rst asserted mid-operation: queue contents and any pending response are discarded at the next edge.

## Configuration
- RF_FWD_EN defined: a hazarding READ is not blocked. For each matching source, the data of the youngest matching queued entry replaces rf_out_data in the response. Unmatched sources use rf_out_data.
- RF_FWD_EN undefined: a hazard blocks READ (rd_ready=0). Priority rule 3 then drains the queue, and the READ issues once no queued entry matches.

## Test plan
- Reset: hold rst for 2 cycles -> all outputs 0 and wq_count=0; first cycle after release rd_ready=1 (if rd_valid) and wb_ready=1.
- Writeback then read:
  - Stimulus: writeback r3=0x1234 and r5=0xBEEF, wait for the queue to empty, then read src1=3, src2=5.
  - Response: two WRITE cycles with rf_reg1=3 then 5; rsp_data1=0x1234 and rsp_data2=0xBEEF one cycle after the READ.
- Hazard: writeback r7=0xA5A5, then read src1=7 in the next cycle.
  - RF_FWD_EN: READ issues immediately, rsp_data1=0xA5A5.
  - Without the macro: rd_ready=0 for 1 cycle (WRITE of r7), then READ, rsp_data1=0xA5A5.
- Queue full: WQ_DEPTH=2, push 2 writebacks while rd_valid is held with non-hazarding sources -> wb_ready=0 while full; the full condition forces WRITE over READ; the read is accepted after the pop.
- Backpressure: rsp_valid=1 with rsp_ready=0 for 3 cycles -> rd_ready=0 and rsp_data stable; rsp_ready=1 -> a new READ is accepted the same cycle.
- Drain: drain_req=1 with 2 entries queued -> two WRITE cycles, rd_ready=wb_ready=0 throughout, drain_done=1 the following cycle; drain_req=0 -> back to RUN, drain_done=0.
